// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of the UART tx FIFO write port.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 9,
  parameter int TIMEOUT    = 255,
  localparam int GW        = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0]               req_last,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             fifo_full,
  output logic                             fifo_write,
  output logic [DATA_WIDTH-1:0]            fifo_data,
  output logic [GW-1:0]                    grant_id,
  output logic                             busy,
  output logic                             timeout_err,
  input  logic                             timeout_clear
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]            r_state;
  logic [GW-1:0]         r_grant;
  logic [15:0]           r_idle;
  logic                  r_terr;
  logic [GW-1:0]         w_pick;
  logic                  w_locked;
  logic                  w_valid;
  logic                  w_last;
  logic                  w_xfer;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_data;

  // Scan upward from the slot after the previous grant; the previous grant itself comes last.
  function automatic logic [GW-1:0] pick(input logic [GW-1:0] base, input logic [NUM_REQ-1:0] v);
    logic [GW-1:0] idx;
    logic          found;
    pick  = base;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = base + GW'(k);
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign w_pick    = pick(r_grant, req_valid);
  assign w_locked  = (r_state == LOCKED);
  assign w_valid   = req_valid[r_grant];
  assign w_last    = req_last[r_grant];
  assign w_data    = req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_xfer    = w_locked && w_valid && !fifo_full;
  assign w_timeout = w_locked && !w_valid && (r_idle == 16'(TIMEOUT - 1));

  assign req_ready   = w_xfer ? (NUM_REQ'(1) << r_grant) : '0;
  assign fifo_write  = w_xfer;
  assign fifo_data   = w_xfer ? w_data : '0;
  assign grant_id    = r_grant;
  assign busy        = w_locked;
  assign timeout_err = r_terr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= GW'(NUM_REQ - 1);
      r_idle  <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_terr <= w_timeout ? 1'b1 : (timeout_clear ? 1'b0 : r_terr);
      if (!w_locked) begin
        r_idle <= '0;
        if (enable && |req_valid) begin
          r_grant <= w_pick;
          r_state <= LOCKED;
        end
      end else if ((w_xfer && w_last) || w_timeout) begin
        r_state <= IDLE;
        r_idle  <= '0;
      end else begin
        r_idle <= w_valid ? '0 : r_idle + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table for arbitration, reset, enable and timeout, plus a hand-driven stall sequence.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [35:0] req_data = {9'h0A3, 9'h0A2, 9'h0A1, 9'h0A0};
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_write;
  logic [8:0]  fifo_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic        timeout_clear = 1'b0;

  int checks = 0;
  int failures = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(9), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write(fifo_write),
    .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
    .timeout_clear(timeout_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en;
    logic [3:0] v, l;
    logic       full, clr;
    logic [3:0] rdy;
    logic       wr;
    logic [8:0] fd;
    logic [1:0] gid;
    logic       bsy, terr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rst, logic en, logic [3:0] v, logic [3:0] l, logic full, logic clr,
                              logic [3:0] rdy, logic wr, logic [8:0] fd, logic [1:0] gid, logic bsy, logic terr);
    vec_t t;
    t.rst = rst; t.en = en; t.v = v; t.l = l; t.full = full; t.clr = clr;
    t.rdy = rdy; t.wr = wr; t.fd = fd; t.gid = gid; t.bsy = bsy; t.terr = terr;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [3:0] rdy, input logic wr, input logic [8:0] fd,
                         input logic [1:0] gid, input logic bsy, input logic terr);
    chk("req_ready", idx, 32'(req_ready), 32'(rdy));
    chk("fifo_write", idx, 32'(fifo_write), 32'(wr));
    chk("fifo_data", idx, 32'(fifo_data), 32'(fd));
    chk("grant_id", idx, 32'(grant_id), 32'(gid));
    chk("busy", idx, 32'(busy), 32'(bsy));
    chk("timeout_err", idx, 32'(timeout_err), 32'(terr));
  endtask

  logic [8:0] wlog[$];

  initial begin
    // reset and alternating 0/2 grants
    tv.push_back(mk(1,1,4'h0,4'h0,0,0, 4'h0,0,9'h000,2'd3,0,0));
    tv.push_back(mk(0,1,4'h5,4'hF,0,0, 4'h0,0,9'h000,2'd3,0,0));
    tv.push_back(mk(0,1,4'h5,4'hF,0,0, 4'h1,1,9'h0A0,2'd0,1,0));
    tv.push_back(mk(0,1,4'h5,4'hF,0,0, 4'h0,0,9'h000,2'd0,0,0));
    tv.push_back(mk(0,1,4'h5,4'hF,0,0, 4'h4,1,9'h0A2,2'd2,1,0));
    tv.push_back(mk(0,1,4'h5,4'hF,0,0, 4'h0,0,9'h000,2'd2,0,0));
    tv.push_back(mk(0,1,4'h5,4'hF,0,0, 4'h1,1,9'h0A0,2'd0,1,0));
    tv.push_back(mk(0,1,4'h0,4'hF,0,0, 4'h0,0,9'h000,2'd0,0,0));
    // all requesters valid: 0,1,2,3,0
    tv.push_back(mk(1,1,4'hF,4'hF,0,0, 4'h0,0,9'h000,2'd3,0,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h0,0,9'h000,2'd3,0,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h1,1,9'h0A0,2'd0,1,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h0,0,9'h000,2'd0,0,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h2,1,9'h0A1,2'd1,1,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h0,0,9'h000,2'd1,0,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h4,1,9'h0A2,2'd2,1,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h0,0,9'h000,2'd2,0,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h8,1,9'h0A3,2'd3,1,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h0,0,9'h000,2'd3,0,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h1,1,9'h0A0,2'd0,1,0));
    // reset on the 2nd beat of a multi-beat packet
    tv.push_back(mk(0,1,4'hF,4'h0,0,0, 4'h0,0,9'h000,2'd0,0,0));
    tv.push_back(mk(0,1,4'hF,4'h0,0,0, 4'h2,1,9'h0A1,2'd1,1,0));
    tv.push_back(mk(1,1,4'hF,4'h0,0,0, 4'h0,0,9'h000,2'd3,0,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h0,0,9'h000,2'd3,0,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h1,1,9'h0A0,2'd0,1,0));
    tv.push_back(mk(0,1,4'h0,4'h0,0,0, 4'h0,0,9'h000,2'd0,0,0));
    // enable dropped while requester 2 is locked
    tv.push_back(mk(0,1,4'h4,4'h0,0,0, 4'h0,0,9'h000,2'd0,0,0));
    tv.push_back(mk(0,0,4'h4,4'h0,0,0, 4'h4,1,9'h0A2,2'd2,1,0));
    tv.push_back(mk(0,0,4'h4,4'h4,0,0, 4'h4,1,9'h0A2,2'd2,1,0));
    tv.push_back(mk(0,0,4'hF,4'hF,0,0, 4'h0,0,9'h000,2'd2,0,0));
    tv.push_back(mk(0,0,4'hF,4'hF,0,0, 4'h0,0,9'h000,2'd2,0,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h0,0,9'h000,2'd2,0,0));
    tv.push_back(mk(0,1,4'hF,4'hF,0,0, 4'h8,1,9'h0A3,2'd3,1,0));
    tv.push_back(mk(0,1,4'h0,4'h0,0,0, 4'h0,0,9'h000,2'd3,0,0));
    // requester 3 goes quiet after one beat: forced release after 4 idle cycles
    tv.push_back(mk(0,1,4'h8,4'h0,0,0, 4'h0,0,9'h000,2'd3,0,0));
    tv.push_back(mk(0,1,4'h8,4'h0,0,0, 4'h8,1,9'h0A3,2'd3,1,0));
    tv.push_back(mk(0,1,4'h0,4'h0,0,0, 4'h0,0,9'h000,2'd3,1,0));
    tv.push_back(mk(0,1,4'h0,4'h0,0,0, 4'h0,0,9'h000,2'd3,1,0));
    tv.push_back(mk(0,1,4'h0,4'h0,0,0, 4'h0,0,9'h000,2'd3,1,0));
    tv.push_back(mk(0,1,4'h0,4'h0,0,0, 4'h0,0,9'h000,2'd3,1,0));
    tv.push_back(mk(0,1,4'h0,4'h0,0,0, 4'h0,0,9'h000,2'd3,0,1));
    tv.push_back(mk(0,1,4'h0,4'h0,0,1, 4'h0,0,9'h000,2'd3,0,1));
    tv.push_back(mk(0,1,4'h0,4'h0,0,0, 4'h0,0,9'h000,2'd3,0,0));

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk);
      #1;
      reset = tv[i].rst; enable = tv[i].en; req_valid = tv[i].v; req_last = tv[i].l;
      fifo_full = tv[i].full; timeout_clear = tv[i].clr;
      @(negedge clk);
      chk_all(i, tv[i].rdy, tv[i].wr, tv[i].fd, tv[i].gid, tv[i].bsy, tv[i].terr);
    end

    // requester 1: 3-beat packet, 5-cycle stall on beat 2, 10-cycle stall on beat 3
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      req_valid = (c == 19) ? 4'h0 : 4'h2;
      req_data[17:9] = (c < 2) ? 9'h041 : (c < 8) ? 9'h042 : 9'h143;
      req_last = (c >= 8) ? 4'h2 : 4'h0;
      fifo_full = (c >= 2 && c <= 6) || (c >= 8 && c <= 17);
      @(negedge clk);
      if (fifo_write) wlog.push_back(fifo_data);
      if (c == 0) chk("stall_idle_busy", 1000 + c, 32'(busy), 32'd0);
      if (c >= 2 && c <= 17 && c != 7) begin
        chk("stall_ready", 1000 + c, 32'(req_ready), 32'd0);
        chk("stall_busy", 1000 + c, 32'(busy), 32'd1);
        chk("stall_terr", 1000 + c, 32'(timeout_err), 32'd0);
      end
      if (c == 1 || c == 7 || c == 18) chk("stall_ready_xfer", 1000 + c, 32'(req_ready), 32'h2);
      if (c == 19) chk("stall_end_busy", 1000 + c, 32'(busy), 32'd0);
    end
    chk("stall_write_count", 2000, 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("stall_beat0", 2001, 32'(wlog[0]), 32'h041);
      chk("stall_beat1", 2002, 32'(wlog[1]), 32'h042);
      chk("stall_beat2", 2003, 32'(wlog[2]), 32'h143);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
